// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main sequencer for the multicycle processor. It steps the shared ALU,
// memory port and register file through FETCH, DECODE and then an
// instruction-specific path. It also owns the NZCV flag register, evaluates
// the condition field once per instruction, and gates every architectural
// write enable with that result.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   reset      in   synchronous, active-low
//   Op         in   Instr[27:26]
//   Funct      in   Instr[25:20]: [5] I, [4:1] cmd, [0] S (data) / L (memory)
//   Cond       in   Instr[31:28]
//   ALUFlags   in   N, Z, C, V from the ALU for the current cycle
//   IRWrite    out  instruction register load
//   AdrSrc     out  memory address select (0 PC, 1 ALUOut)
//   ALUSrcA    out  ALU A select (0 RD1, 1 PC)
//   ALUSrcB    out  ALU B select (00 RD2, 01 ExtImm, 10 constant 4)
//   ResultSrc  out  result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUControl out  000 ADD, 001 SUB, 010 AND, 011 ORR
//   PCWrite    out  PC load
//   RegWrite   out  register file write
//   MemWrite   out  data memory write
//   State      out  current state encoding, debug only
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } ctrlState_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  ctrlState_e state_q;
  ctrlState_e state_d;
  ctrlState_e decState;

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       condReg_q;
  logic       condReg_d;

  logic       flagN;
  logic       flagZ;
  logic       flagC;
  logic       flagV;
  logic       condEx;

  logic [3:0] cmd;
  logic       sBit;
  logic [2:0] dpAluCtrl;
  logic       noWrite;
  logic       updAll;
  logic       updNz;

  logic       irW;
  logic       nextPc;
  logic       branch;
  logic       regW;
  logic       memW;
  logic       aluOp;

  logic       isExecute;
  logic       isMemWb;

  assign {flagN, flagZ, flagC, flagV} = flags_q;
  assign cmd  = Funct[4:1];
  assign sBit = Funct[0];

  assign isExecute = (state_q == EXECUTER) || (state_q == EXECUTEI);
  assign isMemWb   = (state_q == MEMWB);

  // State, flag and condition registers. Reset is synchronous so an
  // instruction caught mid-flight is simply abandoned on the reset edge and
  // the next released cycle starts a clean FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      condReg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      condReg_q <= condReg_d;
    end
  end

  // Next-state sequencing. Illegal encodings fall through to the default
  // and recover to FETCH; the undefined opcode also returns to FETCH after
  // DECODE without touching anything.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        state_d = MEMWB;
      end
      EXECUTER, EXECUTEI: begin
        state_d = ALUWB;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Condition evaluation against the committed flags. The result is only
  // captured at the end of DECODE; holding it for the rest of the
  // instruction means an S-suffixed instruction cannot flip its own
  // predicate when it updates the flags in EXECUTE.
  always_comb begin
    condEx = 1'b0;
    case (Cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  always_comb begin
    condReg_d = condReg_q;
    if (state_q == DECODE) begin
      condReg_d = condEx;
    end
  end

  // Data-processing command decode. NoWrite is derived from cmd alone
  // rather than from the ALUOp path because it has to be valid in ALUWB,
  // where the ALU itself is idle. CMP and any unsupported command suppress
  // the register write; unsupported commands also leave the flags alone.
  always_comb begin
    dpAluCtrl = 3'b000;
    noWrite   = 1'b0;
    updAll    = 1'b0;
    updNz     = 1'b0;
    case (cmd)
      CMD_ADD: begin
        dpAluCtrl = 3'b000;
        updAll    = 1'b1;
      end
      CMD_SUB: begin
        dpAluCtrl = 3'b001;
        updAll    = 1'b1;
      end
      CMD_AND: begin
        dpAluCtrl = 3'b010;
        updNz     = 1'b1;
      end
      CMD_ORR: begin
        dpAluCtrl = 3'b011;
        updNz     = 1'b1;
      end
      CMD_CMP: begin
        dpAluCtrl = 3'b001;
        noWrite   = 1'b1;
        updAll    = 1'b1;
      end
      default: begin
        dpAluCtrl = 3'b000;
        noWrite   = 1'b1;
      end
    endcase
  end

  // Flag register update. ALUFlags are taken at the end of the EXECUTE
  // cycle, only for S-suffixed instructions whose condition passed. Logical
  // operations refresh N and Z but keep the previous carry and overflow.
  always_comb begin
    flags_d = flags_q;
    if (isExecute && sBit && condReg_q) begin
      if (updAll) begin
        flags_d = ALUFlags;
      end else if (updNz) begin
        flags_d[3:2] = ALUFlags[3:2];
      end
    end
  end

  // While reset is held the datapath controls are decoded as if in FETCH,
  // so the muxes sit at their fetch settings regardless of where the
  // sequencer was when reset arrived.
  assign decState = reset ? state_q : FETCH;

  // Moore decode of the datapath controls and the ungated write requests.
  // Everything starts at zero so states that only need a few fields set
  // stay short.
  always_comb begin
    irW       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    aluOp     = 1'b0;
    nextPc    = 1'b0;
    branch    = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    case (decState)
      FETCH: begin
        irW       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        nextPc    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        memW      = 1'b1;
      end
      EXECUTER: begin
        aluOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        aluOp     = 1'b1;
      end
      ALUWB: begin
        regW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: begin
        irW       = 1'b0;
      end
    endcase
  end

  assign ALUControl = aluOp ? dpAluCtrl : 3'b000;

  // Architectural write enables. Conditional writes use the predicate
  // captured in DECODE; loads ignore NoWrite because the cmd bits of a
  // memory instruction are not a data-processing command. Every enable is
  // killed while reset is low so an aborted instruction commits nothing.
  assign IRWrite  = reset & irW;
  assign PCWrite  = reset & (nextPc | (branch & condReg_q));
  assign RegWrite = reset & regW & condReg_q & ~(noWrite & ~isMemWb);
  assign MemWrite = reset & memW & condReg_q;

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Self-checking bench for the multicycle sequencer. Each scenario task pushes
// one expected output vector per clock cycle (plus the instruction fields to
// present once FETCH has been sampled) into a scoreboard queue, then pops and
// compares one entry per falling edge. Flags are internal, so their contents
// are observed through later conditional branches.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] State;

  int checks;
  int errors;

  typedef struct {
    logic [16:0] v;
    string       tag;
    logic        load;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cond;
    logic [3:0]  alu;
  } sbEntry_t;

  sbEntry_t sbQ[$];

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .State      (State)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequencer never lets a scenario finish.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Packs the observed outputs in the same order as expVec.
  function automatic logic [16:0] obsVec();
    return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            ALUControl, PCWrite, RegWrite, MemWrite};
  endfunction

  // Expected output vector built from the per-state Moore table. The caller
  // supplies ALUControl and the gated enables for the cycle.
  function automatic logic [16:0] expVec(input logic [3:0] st,
                                         input logic [2:0] aluc,
                                         input logic pcw,
                                         input logic rw,
                                         input logic mw,
                                         input logic inRst);
    logic       irw;
    logic       adr;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] res;
    irw  = 1'b0;
    adr  = 1'b0;
    srcA = 1'b0;
    srcB = 2'b00;
    res  = 2'b00;
    case (st)
      4'd0: begin irw = ~inRst; srcA = 1'b1; srcB = 2'b10; res = 2'b10; end
      4'd1: begin srcA = 1'b1; srcB = 2'b10; res = 2'b10; end
      4'd2: begin srcB = 2'b01; end
      4'd3: begin adr = 1'b1; end
      4'd4: begin res = 2'b01; end
      4'd5: begin adr = 1'b1; end
      4'd7: begin srcB = 2'b01; end
      4'd9: begin srcB = 2'b01; res = 2'b10; end
      default: begin end
    endcase
    return {st, irw, adr, srcA, srcB, res, aluc, pcw, rw, mw};
  endfunction

  task automatic applyStimulus(input sbEntry_t e);
    Op       = e.op;
    Funct    = e.funct;
    Cond     = e.cond;
    ALUFlags = e.alu;
  endtask

  task automatic pushState(input string tag, input logic [3:0] st,
                           input logic [2:0] aluc, input logic pcw,
                           input logic rw, input logic mw);
    sbEntry_t e;
    e.v = expVec(st, aluc, pcw, rw, mw, 1'b0);
    e.tag = tag;
    e.load = 1'b0;
    e.op = 2'b00;
    e.funct = 6'b000000;
    e.cond = 4'b0000;
    e.alu = 4'b0000;
    sbQ.push_back(e);
  endtask

  task automatic pushFetch(input string tag, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] cond,
                           input logic [3:0] alu);
    sbEntry_t e;
    e.v = expVec(4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    e.tag = {tag, "_fetch"};
    e.load = 1'b1;
    e.op = op;
    e.funct = funct;
    e.cond = cond;
    e.alu = alu;
    sbQ.push_back(e);
  endtask

  task automatic pushBranch(input string tag, input logic [3:0] cond,
                            input logic taken);
    pushFetch(tag, 2'b10, 6'b000000, cond, 4'b0000);
    pushState({tag, "_decode"}, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
    pushState({tag, "_branch"}, 4'd9, 3'b000, taken, 1'b0, 1'b0);
  endtask

  task automatic pushDp(input string tag, input logic [5:0] funct,
                        input logic [3:0] cond, input logic [3:0] alu,
                        input logic [2:0] aluc, input logic rw);
    pushFetch(tag, 2'b00, funct, cond, alu);
    pushState({tag, "_decode"}, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
    pushState({tag, "_execute"}, funct[5] ? 4'd7 : 4'd6, aluc, 1'b0, 1'b0, 1'b0);
    pushState({tag, "_aluwb"}, 4'd8, 3'b000, 1'b0, rw, 1'b0);
  endtask

  task automatic pushMem(input string tag, input logic isLoad,
                         input logic [3:0] cond, input logic pass);
    pushFetch(tag, 2'b01, isLoad ? 6'b011001 : 6'b011000, cond, 4'b0000);
    pushState({tag, "_decode"}, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
    pushState({tag, "_memadr"}, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0);
    if (isLoad) begin
      pushState({tag, "_memread"}, 4'd3, 3'b000, 1'b0, 1'b0, 1'b0);
      pushState({tag, "_memwb"}, 4'd4, 3'b000, 1'b0, pass, 1'b0);
    end else begin
      pushState({tag, "_memwrite"}, 4'd5, 3'b000, 1'b0, 1'b0, pass);
    end
  endtask

  // Power-on reset: three reset edges, then release into an undefined
  // instruction so the first FETCH/DECODE pair can be checked directly.
  task automatic test_reset();
    logic [16:0] got;
    logic [16:0] rstVec;
    rstVec = expVec(4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obsVec();
      checks++;
      if (got !== rstVec) begin
        errors++;
        $display("[TB] FAIL reset_hold%0d: got %h expected %h", i, got, rstVec);
      end
    end
    reset = 1'b1;
    Op = 2'b11;
    #1;
    got = obsVec();
    checks++;
    if (got !== expVec(4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL reset_first_fetch: got %h expected %h", got,
               expVec(4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    got = obsVec();
    checks++;
    if (got !== expVec(4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL reset_undef_decode: got %h expected %h", got,
               expVec(4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_ldr();
    sbEntry_t    e;
    logic [16:0] got;
    pushMem("ldr_al", 1'b1, 4'b1110, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  task automatic test_subs_beq();
    sbEntry_t    e;
    logic [16:0] got;
    pushBranch("beq_flags0", 4'b0000, 1'b0);
    pushDp("subs_z", 6'b000101, 4'b1110, 4'b0100, 3'b001, 1'b1);
    pushBranch("beq_after_subs", 4'b0000, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // Flags are Z=1 here, so every NE instruction fails its condition but
  // still spends its full cycle count.
  task automatic test_cond_fail();
    sbEntry_t    e;
    logic [16:0] got;
    pushBranch("bne_z1", 4'b0001, 1'b0);
    pushMem("strne_z1", 1'b0, 4'b0001, 1'b0);
    pushDp("addsne_z1", 6'b001001, 4'b0001, 4'b0000, 3'b000, 1'b0);
    pushBranch("beq_after_failed_adds", 4'b0000, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // SUBSEQ clears Z during its own EXECUTE; its write in ALUWB must still
  // happen because the predicate was captured in DECODE.
  task automatic test_cond_hold();
    sbEntry_t    e;
    logic [16:0] got;
    pushDp("subseq_clears_z", 6'b000101, 4'b0000, 4'b0000, 3'b001, 1'b1);
    pushBranch("bne_after_clear", 4'b0001, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  task automatic test_cmp();
    sbEntry_t    e;
    logic [16:0] got;
    pushDp("cmp_c", 6'b010101, 4'b1110, 4'b0010, 3'b001, 1'b0);
    pushBranch("bcs_after_cmp", 4'b0010, 1'b1);
    pushBranch("bhi_after_cmp", 4'b1000, 1'b1);
    pushBranch("beq_after_cmp", 4'b0000, 1'b0);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // CMP leaves flags 0011. ANDS with 1011 gives 1011; ORRS (immediate form)
  // with 0100 then gives 0111, proving C and V were kept.
  task automatic test_ands();
    sbEntry_t    e;
    logic [16:0] got;
    pushDp("cmp_cv", 6'b010101, 4'b1110, 4'b0011, 3'b001, 1'b0);
    pushDp("ands", 6'b000001, 4'b1110, 4'b1011, 3'b010, 1'b1);
    pushBranch("bmi_after_ands", 4'b0100, 1'b1);
    pushBranch("bge_after_ands", 4'b1010, 1'b1);
    pushBranch("bvs_after_ands", 4'b0110, 1'b1);
    pushDp("orrs_imm", 6'b111001, 4'b1110, 4'b0100, 3'b011, 1'b1);
    pushBranch("beq_after_orrs", 4'b0000, 1'b1);
    pushBranch("bvs_after_orrs", 4'b0110, 1'b1);
    pushBranch("bcs_after_orrs", 4'b0010, 1'b1);
    pushBranch("bmi_after_orrs", 4'b0100, 1'b0);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // Flags are 0111. ADD without S and an unsupported command must leave
  // them untouched; the unsupported command also must not write.
  task automatic test_no_update();
    sbEntry_t    e;
    logic [16:0] got;
    pushDp("add_nos", 6'b001000, 4'b1110, 4'b1111, 3'b000, 1'b1);
    pushDp("unsupported_s", 6'b011111, 4'b1110, 4'b1111, 3'b000, 1'b0);
    pushBranch("bmi_unchanged", 4'b0100, 1'b0);
    pushBranch("bne_unchanged", 4'b0001, 1'b0);
    pushBranch("blt_unchanged", 4'b1011, 1'b1);
    pushBranch("bnever", 4'b1111, 1'b0);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // Undefined opcode, then memory instructions with GT (false), LE (true)
  // and AL, issued without gaps.
  task automatic test_back_to_back();
    sbEntry_t    e;
    logic [16:0] got;
    pushFetch("undef", 2'b11, 6'b000000, 4'b1110, 4'b0000);
    pushState("undef_decode", 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
    pushMem("ldrgt", 1'b1, 4'b1100, 1'b0);
    pushMem("strle", 1'b0, 4'b1101, 1'b1);
    pushMem("ldr_al2", 1'b1, 4'b1110, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  // Reset asserted in MEMWRITE kills the store at once, clears the flags
  // (previously 0111) and restarts at FETCH.
  task automatic test_reset_mid_store();
    sbEntry_t    e;
    logic [16:0] got;
    logic [16:0] rstVec;
    rstVec = expVec(4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    pushMem("str_abort", 1'b0, 4'b1110, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || State !== 4'd5) begin
      errors++;
      $display("[TB] FAIL abort_memwrite: got MemWrite=%b State=%0d expected MemWrite=0 State=5",
               MemWrite, State);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obsVec();
      checks++;
      if (got !== rstVec) begin
        errors++;
        $display("[TB] FAIL abort_hold%0d: got %h expected %h", i, got, rstVec);
      end
    end
    reset = 1'b1;
    Op = 2'b11;
    #1;
    got = obsVec();
    checks++;
    if (got !== expVec(4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL abort_first_fetch: got %h expected %h", got,
               expVec(4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    got = obsVec();
    checks++;
    if (got !== expVec(4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL abort_undef_decode: got %h expected %h", got,
               expVec(4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    pushBranch("beq_flags_cleared", 4'b0000, 1'b0);
    pushBranch("bcs_flags_cleared", 4'b0010, 1'b0);
    pushBranch("bvs_flags_cleared", 4'b0110, 1'b0);
    pushBranch("bpl_flags_cleared", 4'b0101, 1'b1);
    while (sbQ.size() != 0) begin
      @(negedge clk);
      e = sbQ.pop_front();
      got = obsVec();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.v);
      end
      if (e.load) applyStimulus(e);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    Op       = 2'b11;
    Funct    = 6'b000000;
    Cond     = 4'b1110;
    ALUFlags = 4'b0000;
    $display("[TB] starting multicycle_ctrl_fsm bench");
    test_reset();
    test_ldr();
    test_subs_beq();
    test_cond_fail();
    test_cond_hold();
    test_cmp();
    test_ands();
    test_no_update();
    test_back_to_back();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
